// File: rtl/instr_fetch.sv
// Fetch stage: keeps the PC, issues one instruction-memory read at a time, and hands {instr, pc} to decode.
// Define IFETCH_MISALIGN_CHECK_EN to add the misaligned-redirect FAULT/PARK path; without it out_fault is 0.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_FAULT = 3'd3,
        S_PARK  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;

    logic        w_req_hs;
    logic        w_busy;
    logic        w_pend_next;
    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_inc;

    assign imem_req_valid = rst_n && (r_state == S_REQ);
    assign imem_addr      = r_pc;
    assign out_valid      = r_out_valid;
    assign out_instr      = r_out_instr;
    assign out_pc         = r_out_pc;

    assign w_req_hs    = imem_req_valid && imem_req_ready;
    // A read is owed by memory while waiting, or while a killed read is still pending from FAULT/PARK.
    assign w_busy      = (r_state == S_WAIT) || r_kill;
    // Whether a read will still be outstanding after this edge; a redirect turns it into a killed read.
    assign w_pend_next = w_req_hs || (w_busy && !imem_rsp_valid);
    assign w_redir_pc  = redirect_pc & ~32'h3;
    assign w_pc_inc    = r_pc + 32'd4;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic r_out_fault;
    logic w_misalign;
    assign w_misalign = |redirect_pc[1:0];
    assign out_fault  = r_out_fault;
`else
    assign out_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_VECTOR;
            r_kill      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            r_out_pc    <= RESET_VECTOR;
`ifdef IFETCH_MISALIGN_CHECK_EN
            r_out_fault <= 1'b0;
`endif
        end else if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_kill      <= w_pend_next;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            r_state     <= w_pend_next ? S_WAIT : S_REQ;
`ifdef IFETCH_MISALIGN_CHECK_EN
            r_out_fault <= 1'b0;
            if (w_misalign) begin
                r_state     <= S_FAULT;
                r_out_valid <= 1'b1;
                r_out_fault <= 1'b1;
                r_out_pc    <= redirect_pc;
            end
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_out_instr <= imem_rsp_data;
                            r_out_pc    <= r_pc;
                            r_pc        <= w_pc_inc;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_instr <= NOP_INSTR;
                        r_state     <= S_REQ;
                    end
                end
`ifdef IFETCH_MISALIGN_CHECK_EN
                S_FAULT: begin
                    if (imem_rsp_valid)
                        r_kill <= 1'b0;
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_fault <= 1'b0;
                        r_state     <= S_PARK;
                    end
                end
                S_PARK: begin
                    if (imem_rsp_valid)
                        r_kill <= 1'b0;
                end
`endif
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
